// File: rtl/booth_mult_pkg.sv
// Shared constants for the radix-4 Booth / Wallace 16x16 multiplier datapath.
package booth_mult_pkg;

   localparam int MULT_W    = 16;
   localparam int PROD_W    = 2 * MULT_W;
   localparam int CPA_SPLIT = 16;

   typedef logic [PROD_W-1:0] prod_t;

endpackage : booth_mult_pkg

// File: rtl/final_cpa_pipe_cpa_slice.sv
// N-bit combinational adder slice with carry in/out, used for each half of the
// final carry-propagate add.
module cpa_slice #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] full_sum;

   // One extra bit catches the carry out of the top position.
   assign full_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
   assign s        = full_sum[N-1:0];
   assign cout     = full_sum[N];

endmodule : cpa_slice

// File: rtl/final_cpa_pipe.sv
// Final carry-propagate adder of the Booth/Wallace multiplier. The 32-bit add
// of the sum and carry rows is cut at SPLIT: the low half is added in front of
// stage 1, the high half (plus the registered low carry) in front of stage 2.
// Both stages use a valid/ready handshake; capacity is two transactions.
module final_cpa_pipe
   import booth_mult_pkg::*;
#(
   parameter int WIDTH = PROD_W,
   parameter int SPLIT = CPA_SPLIT
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_row,
   input  logic [WIDTH-1:0] carry_row,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product
);

   localparam int HI_W = WIDTH - SPLIT;

   logic             s1_valid;
   logic [SPLIT-1:0] s1_lo;
   logic             s1_c;
   logic [HI_W-1:0]  s1_hi_a;
   logic [HI_W-1:0]  s1_hi_b;

   logic             s2_ready;
   logic [SPLIT-1:0] lo_sum;
   logic             lo_cout;
   logic [HI_W-1:0]  hi_sum;
   logic             hi_cout_unused;

   // Ready depends only on register state and out_ready, never on in_valid.
   assign s2_ready = ~out_valid | out_ready;
   assign in_ready = ~s1_valid | s2_ready;

   cpa_slice #(.N(SPLIT)) u_lo_add (
      .a    (sum_row[SPLIT-1:0]),
      .b    (carry_row[SPLIT-1:0]),
      .cin  (1'b0),
      .s    (lo_sum),
      .cout (lo_cout)
   );

   // Carry out of the MSB is dropped: Booth sign extension makes the wrap correct.
   cpa_slice #(.N(HI_W)) u_hi_add (
      .a    (s1_hi_a),
      .b    (s1_hi_b),
      .cin  (s1_c),
      .s    (hi_sum),
      .cout (hi_cout_unused)
   );

   // Stage 1: low-half sum and carry, raw high-half operands; holds when stalled.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_c     <= 1'b0;
         s1_hi_a  <= '0;
         s1_hi_b  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_lo   <= lo_sum;
            s1_c    <= lo_cout;
            s1_hi_a <= sum_row[WIDTH-1:SPLIT];
            s1_hi_b <= carry_row[WIDTH-1:SPLIT];
         end
      end
   end

   // Stage 2: completes the high half and presents the product; holds when stalled.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         out_valid <= 1'b0;
         product   <= '0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            product <= {hi_sum, s1_lo};
         end
      end
   end

endmodule : final_cpa_pipe
